// File: rtl/ivs_dma_burst_split_if.sv
// Command / burst-request bundle for ivs_dma_burst_split.
//   slave  : DMA burst splitter side (takes commands, issues rd/wr bursts, done)
//   master : command source and AR/AW consumer side
// Signals: cmd_valid/ready, cmd_src_addr, cmd_dst_addr, cmd_len (beats),
//          rd_valid/ready, rd_addr, rd_len (beats-1), wr_* likewise, done pulse.
interface ivs_dma_burst_split_if #(
  parameter int unsigned LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_src_addr;
  logic [31:0]      cmd_dst_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_addr;
  logic [5:0]       rd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_addr;
  logic [5:0]       wr_len;
  logic             done;

  modport slave (
    input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, rd_ready, wr_ready,
    output cmd_ready, rd_valid, rd_addr, rd_len, wr_valid, wr_addr, wr_len, done
  );

  modport master (
    output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, rd_ready, wr_ready,
    input  cmd_ready, rd_valid, rd_addr, rd_len, wr_valid, wr_addr, wr_len, done
  );
endinterface

// File: rtl/ivs_dma_burst_split.sv
// ivs_dma_burst_split: splits one DMA copy command into AXI-legal read and
// write burst requests (at most MAX_BEATS beats, never crossing a 4 KB page).
// The read and write streams advance independently; done pulses once when
// both have issued every burst and the block is back in IDLE.
// Ports:
//   aclk, arst_n : clock, asynchronous active-low reset
//   bus          : ivs_dma_burst_split_if.slave (cmd, rd, wr, done)
// Optional feature macro DMA_SPLIT_STAT_EN adds per-command burst counters
//   stat_rd_bursts / stat_wr_bursts (cleared on command, saturating).
module ivs_dma_burst_split #(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned LEN_W     = 16
) (
  input  logic aclk,
  input  logic arst_n,
  ivs_dma_burst_split_if.slave bus
`ifdef DMA_SPLIT_STAT_EN
  ,
  output logic [15:0] stat_rd_bursts,
  output logic [15:0] stat_wr_bursts
`endif
);

  // Wide enough for both the remaining length and the 4 KB page room (256).
  localparam int unsigned CW    = (LEN_W > 9) ? LEN_W : 9;
  localparam int unsigned N_CH  = 2;  // channel 0 = read, 1 = write

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        done_q, done_d;
  logic [N_CH-1:0][31:0]       addr_q, addr_d;
  logic [N_CH-1:0][LEN_W-1:0]  rem_q, rem_d;   // beats not yet handed off, incl. presented burst
  logic [N_CH-1:0][5:0]        len_q, len_d;
  logic [N_CH-1:0]             valid_q, valid_d;
  logic [N_CH-1:0][31:0]       base_addr;
  logic [N_CH-1:0]             ready;
  logic                        cmd_fire;

  logic [31:0]                 nxt_addr;
  logic [LEN_W-1:0]            nxt_rem;
  logic [6:0]                  nxt_beats;
  logic                        load;

`ifdef DMA_SPLIT_STAT_EN
  logic [N_CH-1:0][15:0]       stat_q, stat_d;
`endif

  // Address bits [3:0] are forced to zero; keep them visibly sunk.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.cmd_src_addr[3:0], bus.cmd_dst_addr[3:0]};

  assign base_addr[0] = {bus.cmd_src_addr[31:4], 4'h0};
  assign base_addr[1] = {bus.cmd_dst_addr[31:4], 4'h0};
  assign ready        = {bus.wr_ready, bus.rd_ready};
  assign cmd_fire     = bus.cmd_valid & cmd_ready_q;

  // Beats for the next burst: min(remaining, MAX_BEATS, beats left in 4 KB page).
  function automatic logic [6:0] burst_beats(input logic [7:0] page_beat,
                                             input logic [LEN_W-1:0] rem);
    logic [CW-1:0] b;
    logic [CW-1:0] room;
    b    = CW'(rem);
    room = CW'(9'd256 - {1'b0, page_beat});
    if (b > CW'(MAX_BEATS)) b = CW'(MAX_BEATS);
    if (b > room)           b = room;
    return 7'(b);
  endfunction

  // Next-state: per-channel burst walk plus command FSM.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    valid_d   = valid_q;
    nxt_addr  = '0;
    nxt_rem   = '0;
    nxt_beats = '0;
    load      = 1'b0;
`ifdef DMA_SPLIT_STAT_EN
    stat_d    = stat_q;
`endif

    for (int c = 0; c < int'(N_CH); c++) begin
      nxt_addr  = '0;
      nxt_rem   = '0;
      nxt_beats = '0;
      load      = 1'b0;
      if (cmd_fire) begin
        nxt_addr = base_addr[c];
        nxt_rem  = bus.cmd_len;
        load     = 1'b1;
      end else if (valid_q[c] && ready[c]) begin
        // Advance past the burst just taken; the sum wraps modulo 2^32.
        nxt_addr = addr_q[c] + {21'd0, 7'(len_q[c]) + 7'd1, 4'd0};
        nxt_rem  = rem_q[c] - LEN_W'(len_q[c]) - LEN_W'(1'b1);
        load     = 1'b1;
      end
      if (load) begin
        nxt_beats  = burst_beats(nxt_addr[11:4], nxt_rem);
        addr_d[c]  = nxt_addr;
        rem_d[c]   = nxt_rem;
        valid_d[c] = (nxt_rem != '0);
        len_d[c]   = (nxt_rem != '0) ? 6'(nxt_beats - 7'd1) : 6'd0;
      end
`ifdef DMA_SPLIT_STAT_EN
      if (cmd_fire) begin
        stat_d[c] = 16'd0;
      end else if (valid_q[c] && ready[c] && (stat_q[c] != 16'hFFFF)) begin
        stat_d[c] = stat_q[c] + 16'd1;
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_len == '0) done_d  = 1'b1;
          else                   state_d = BUSY;
        end
      end
      BUSY: begin
        if ((rem_d[0] == '0) && (rem_d[1] == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      valid_q     <= '0;
`ifdef DMA_SPLIT_STAT_EN
      stat_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
`ifdef DMA_SPLIT_STAT_EN
      stat_q      <= stat_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.rd_valid  = valid_q[0];
  assign bus.rd_addr   = addr_q[0];
  assign bus.rd_len    = len_q[0];
  assign bus.wr_valid  = valid_q[1];
  assign bus.wr_addr   = addr_q[1];
  assign bus.wr_len    = len_q[1];

`ifdef DMA_SPLIT_STAT_EN
  assign stat_rd_bursts = stat_q[0];
  assign stat_wr_bursts = stat_q[1];
`endif

endmodule

// File: tb/tb_ivs_dma_burst_split.sv
// Self-checking bench for ivs_dma_burst_split: table of commands checked
// against a burst scoreboard, plus hand-written corner sequences
// (first-burst timing, zero length, back-pressure hold, wrap, async reset).
module tb_ivs_dma_burst_split;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  ivs_dma_burst_split_if #(.LEN_W(16)) bus ();

`ifdef DMA_SPLIT_STAT_EN
  logic [15:0] stat_rd_bursts, stat_wr_bursts;
`endif

  ivs_dma_burst_split #(.MAX_BEATS(16), .LEN_W(16)) dut (
    .aclk   (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
`ifdef DMA_SPLIT_STAT_EN
    ,
    .stat_rd_bursts (stat_rd_bursts),
    .stat_wr_bursts (stat_wr_bursts)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  len;
  } burst_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    bit          rd_rnd;
    bit          wr_rnd;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  burst_t rd_q[$];
  burst_t wr_q[$];
  vec_t   vecs[7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_hs_cnt = 0, wr_hs_cnt = 0;
  int rd_base = 0, wr_base = 0;
  int last_hs_cyc = 0;

  // Ready drivers: random or held level, updated just after each rising edge.
  bit   rd_rnd = 1'b0, wr_rnd = 1'b0;
  logic rd_hold = 1'b1, wr_hold = 1'b1;
  logic rd_ready_q = 1'b0, wr_ready_q = 1'b0;
  assign bus.rd_ready = rd_ready_q;
  assign bus.wr_ready = wr_ready_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    rd_ready_q = rd_rnd ? 1'($urandom_range(0, 1)) : rd_hold;
    wr_ready_q = wr_rnd ? 1'($urandom_range(0, 1)) : wr_hold;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference split of one channel, straight from the burst rules.
  task automatic push_split(input logic [31:0] base, input int len, input bit is_rd);
    logic [31:0] a;
    int r, b, room;
    a = {base[31:4], 4'h0};
    r = len;
    while (r > 0) begin
      room = 256 - int'(a[11:4]);
      b = (r > 16) ? 16 : r;
      if (b > room) b = room;
      if (is_rd) rd_q.push_back({a, 6'(b - 1)});
      else       wr_q.push_back({a, 6'(b - 1)});
      a = a + 32'(b * 16);
      r = r - b;
    end
  endtask

  // Monitor: scoreboard pops on handshakes and hold-while-stalled checks.
  logic   rd_stall_prev = 1'b0, wr_stall_prev = 1'b0;
  burst_t rd_prev, wr_prev, exp_b;

  always @(negedge clk) begin
    if (!arst_n) begin
      rd_stall_prev = 1'b0;
      wr_stall_prev = 1'b0;
    end else begin
      if (rd_stall_prev) begin
        chk("rd_hold_valid", bus.rd_valid, 1'b1);
        chk("rd_hold_addr", bus.rd_addr, rd_prev.addr);
        chk("rd_hold_len", bus.rd_len, rd_prev.len);
      end
      if (wr_stall_prev) begin
        chk("wr_hold_valid", bus.wr_valid, 1'b1);
        chk("wr_hold_addr", bus.wr_addr, wr_prev.addr);
        chk("wr_hold_len", bus.wr_len, wr_prev.len);
      end
      rd_stall_prev = bus.rd_valid && !bus.rd_ready;
      wr_stall_prev = bus.wr_valid && !bus.wr_ready;
      rd_prev = {bus.rd_addr, bus.rd_len};
      wr_prev = {bus.wr_addr, bus.wr_len};
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected_burst: addr 0x%0h len %0d with none expected", bus.rd_addr, bus.rd_len);
        end else begin
          exp_b = rd_q.pop_front();
          chk("rd_addr", bus.rd_addr, exp_b.addr);
          chk("rd_len", bus.rd_len, exp_b.len);
        end
        rd_hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected_burst: addr 0x%0h len %0d with none expected", bus.wr_addr, bus.wr_len);
        end else begin
          exp_b = wr_q.pop_front();
          chk("wr_addr", bus.wr_addr, exp_b.addr);
          chk("wr_len", bus.wr_len, exp_b.len);
        end
        wr_hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (bus.done) chk("done_with_cmd_ready", bus.cmd_ready, 1'b1);
    end
  end

  // Presents one command and returns just after its handshake edge.
  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input bit model);
    bit got;
    @(posedge clk); #1;
    if (model) begin
      push_split(src, int'(len), 1'b1);
      push_split(dst, int'(len), 1'b0);
    end
    bus.cmd_src_addr = src;
    bus.cmd_dst_addr = dst;
    bus.cmd_len      = len;
    bus.cmd_valid    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) got = 1'b1;
    end
    chk("cmd_accept", got, 1'b1);
    rd_base = rd_hs_cnt;
    wr_base = wr_hs_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_rd, input int exp_wr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("done_cmd_ready", bus.cmd_ready, 1'b1);
      chk("done_rd_valid", bus.rd_valid, 1'b0);
      chk("done_wr_valid", bus.wr_valid, 1'b0);
      chk("done_rd_q_empty", rd_q.size(), 0);
      chk("done_wr_q_empty", wr_q.size(), 0);
      chk("rd_burst_count", rd_hs_cnt - rd_base, exp_rd);
      chk("wr_burst_count", wr_hs_cnt - wr_base, exp_wr);
      if (exp_rd + exp_wr > 0) chk("done_latency", cyc, last_hs_cyc + 1);
`ifdef DMA_SPLIT_STAT_EN
      chk("stat_rd_bursts", stat_rd_bursts, exp_rd);
      chk("stat_wr_bursts", stat_wr_bursts, exp_wr);
`endif
      @(negedge clk);
      chk("done_one_cycle", bus.done, 1'b0);
`ifdef DMA_SPLIT_STAT_EN
      chk("stat_rd_hold", stat_rd_bursts, exp_rd);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    vecs[0] = '{32'h1000_0000, 32'h2000_0000, 16'd32,  1'b0, 1'b0, 2,  2};
    vecs[1] = '{32'h0000_0F00, 32'h0000_0008, 16'd100, 1'b1, 1'b1, 7,  7};
    vecs[2] = '{32'h1234_5678, 32'hABCD_EFFF, 16'd1,   1'b1, 1'b0, 1,  1};
    vecs[3] = '{32'h0000_0FF0, 32'h0000_0000, 16'd17,  1'b0, 1'b1, 2,  2};
    vecs[4] = '{32'h0000_5550, 32'h0000_AAA0, 16'd0,   1'b0, 1'b0, 0,  0};
    vecs[5] = '{32'h0000_0FD0, 32'h7FFF_FFF0, 16'd64,  1'b1, 1'b1, 5,  5};
    vecs[6] = '{32'h0000_0000, 32'h0000_0800, 16'd300, 1'b1, 1'b1, 19, 19};

    bus.cmd_valid    = 1'b0;
    bus.cmd_src_addr = '0;
    bus.cmd_dst_addr = '0;
    bus.cmd_len      = '0;
    arst_n = 1'b0;
    #13;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 32'h0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_rd_len", bus.rd_len, 6'd0);
    chk("rst_wr_len", bus.wr_len, 6'd0);
    #10 arst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Table of commands, scoreboarded through the reference split.
    foreach (vecs[i]) begin
      rd_rnd = vecs[i].rd_rnd;
      wr_rnd = vecs[i].wr_rnd;
      send_cmd(vecs[i].src, vecs[i].dst, vecs[i].len, 1'b1);
      wait_done(vecs[i].exp_rd, vecs[i].exp_wr);
      rd_rnd = 1'b0;
      wr_rnd = 1'b0;
    end

    // Page-crossing split with first burst presented the cycle after acceptance.
    rd_q.push_back({32'h0000_0FC0, 6'd3});
    rd_q.push_back({32'h0000_1000, 6'd3});
    wr_q.push_back({32'h0000_3000, 6'd7});
    send_cmd(32'h0000_0FC0, 32'h0000_3000, 16'd8, 1'b0);
    @(negedge clk);
    chk("first_rd_valid", bus.rd_valid, 1'b1);
    chk("first_rd_addr", bus.rd_addr, 32'h0000_0FC0);
    chk("first_rd_len", bus.rd_len, 6'd3);
    chk("first_cmd_ready", bus.cmd_ready, 1'b0);
    wait_done(2, 1);

    // Zero-length command: done and cmd_ready the very next cycle.
    send_cmd(32'h0000_1000, 32'h0000_2000, 16'd0, 1'b0);
    @(negedge clk);
    chk("len0_done", bus.done, 1'b1);
    chk("len0_cmd_ready", bus.cmd_ready, 1'b1);
    chk("len0_rd_valid", bus.rd_valid, 1'b0);
    chk("len0_wr_valid", bus.wr_valid, 1'b0);
    @(negedge clk);
    chk("len0_done_pulse", bus.done, 1'b0);

    // Read stalled 10 cycles while writes stream back-to-back.
    rd_hold = 1'b0;
    send_cmd(32'h1000_0000, 32'h2000_0000, 16'd48, 1'b1);
    repeat (4) @(negedge clk);
    chk("stall_wr_b2b_count", wr_hs_cnt - wr_base, 3);
    chk("stall_wr_valid_low", bus.wr_valid, 1'b0);
    repeat (6) @(negedge clk);
    chk("stall_rd_count", rd_hs_cnt - rd_base, 0);
    chk("stall_rd_addr", bus.rd_addr, 32'h1000_0000);
    chk("stall_no_done", bus.done, 1'b0);
    rd_hold = 1'b1;
    wait_done(3, 3);

    // Address wrap at the top of memory.
    rd_q.push_back({32'hFFFF_FFE0, 6'd1});
    rd_q.push_back({32'h0000_0000, 6'd1});
    wr_q.push_back({32'h0000_0010, 6'd3});
    send_cmd(32'hFFFF_FFE0, 32'h0000_0010, 16'd4, 1'b0);
    wait_done(2, 1);

    // Asynchronous reset after the first read burst of a command.
    send_cmd(32'h1000_0000, 32'h2000_0000, 16'd32, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rd_hs_cnt - rd_base >= 1) got = 1'b1;
    end
    chk("rst_mid_first_burst", got, 1'b1);
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_rst_wr_valid", bus.wr_valid, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("mid_rst_rd_addr", bus.rd_addr, 32'h0);
`ifdef DMA_SPLIT_STAT_EN
    chk("mid_rst_stat_rd", stat_rd_bursts, 16'd0);
`endif
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready_low", bus.cmd_ready, 1'b0);
    chk("rel_no_done", bus.done, 1'b0);
    @(negedge clk);
    chk("rel_cmd_ready_high", bus.cmd_ready, 1'b1);
    send_cmd(32'h1000_0000, 32'h2000_0000, 16'd32, 1'b1);
    wait_done(2, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
